// File: rtl/safe_perm_pkg.sv
// Shared widths, permutation typedef and reference rank function for the
// safe permutation ranker.
package safe_perm_pkg;

   localparam int PERM_SIZE_DEF = 5;
   localparam int PORT_SIZE_DEF = 2;
   localparam int PERM_COUNT    = 24;

   typedef logic [2:0][PORT_SIZE_DEF-1:0] perm_t;

   // Rank of p0,p1,p2 drawn from 0..3; duplicates rank as 0.
   function automatic logic [PERM_SIZE_DEF-1:0] perm_rank(input perm_t p);
      logic [PORT_SIZE_DEF-1:0] r1;
      logic [PORT_SIZE_DEF-1:0] r2;
      logic                     dup;
      r1  = p[1] - PORT_SIZE_DEF'(p[1] > p[0]);
      r2  = p[2] - PORT_SIZE_DEF'(p[0] < p[2]) - PORT_SIZE_DEF'(p[1] < p[2]);
      dup = (p[0] == p[1]) || (p[0] == p[2]) || (p[1] == p[2]);
      if (dup)
         return '0;
      return PERM_SIZE_DEF'(6) * (PERM_SIZE_DEF'(3) - PERM_SIZE_DEF'(p[0]))
           + (PERM_SIZE_DEF'(r1) << 1) + PERM_SIZE_DEF'(r2);
   endfunction

endpackage

// File: rtl/safe_perm_pipe_stage.sv
// Generic valid/ready register slice; an empty slot always accepts, so
// bubbles collapse and a full slot holds its data until drained.
module safe_perm_pipe_stage #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic             valid_d, valid_q;
   logic [WIDTH-1:0] data_d, data_q;

   always_comb begin
      in_ready = !valid_q || out_ready;
      valid_d  = in_ready ? in_valid : valid_q;
      data_d   = (in_ready && in_valid) ? in_data : data_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;

endmodule

// File: rtl/safe_permutation_ranker.sv
// Two-stage ranker mapping a 3-entry port permutation to its index 0..23.
// Optional saturating error counter enabled by SAFE_PERM_RANK_ERR_CNT_EN.
module safe_permutation_ranker
   import safe_perm_pkg::*;
#(
   parameter int PERM_SIZE = PERM_SIZE_DEF,
   parameter int PORT_SIZE = PORT_SIZE_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [3*PORT_SIZE-1:0] in_perm,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [PERM_SIZE-1:0]   out_index,
   output logic                   out_err
`ifdef SAFE_PERM_RANK_ERR_CNT_EN
   ,
   output logic [15:0]            err_count
`endif
);

   localparam int S1_W = PERM_SIZE + 2*PORT_SIZE + 3;
   localparam int S2_W = PERM_SIZE + 1;

   logic [PORT_SIZE-1:0] p0, p1, p2;
   logic [PERM_SIZE-1:0] s1_term_in;
   logic [PORT_SIZE-1:0] s1_r1_in;
   logic                 s1_lt0_in, s1_lt1_in, s1_dup_in;
   logic [S1_W-1:0]      s1_data_in, s1_data;
   logic                 s1_valid, s2_in_ready;

   // S1 keeps p2 raw with its two comparisons; r2 is finished in S2.
   always_comb begin
      p0         = in_perm[0*PORT_SIZE +: PORT_SIZE];
      p1         = in_perm[1*PORT_SIZE +: PORT_SIZE];
      p2         = in_perm[2*PORT_SIZE +: PORT_SIZE];
      s1_term_in = PERM_SIZE'(6) * (PERM_SIZE'(3) - PERM_SIZE'(p0));
      s1_r1_in   = p1 - PORT_SIZE'(p1 > p0);
      s1_lt0_in  = p0 < p2;
      s1_lt1_in  = p1 < p2;
      s1_dup_in  = (p0 == p1) || (p0 == p2) || (p1 == p2);
      s1_data_in = {s1_term_in, s1_r1_in, p2, s1_lt0_in, s1_lt1_in, s1_dup_in};
   end

   safe_perm_pipe_stage #(.WIDTH(S1_W)) u_stage1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (s1_data_in),
      .out_valid (s1_valid),
      .out_ready (s2_in_ready),
      .out_data  (s1_data)
   );

   logic [PERM_SIZE-1:0] s1_term;
   logic [PORT_SIZE-1:0] s1_r1, s1_p2, s2_r2;
   logic                 s1_lt0, s1_lt1, s1_dup;
   logic [PERM_SIZE-1:0] s2_index_in;
   logic [S2_W-1:0]      s2_data_in;

   always_comb begin
      {s1_term, s1_r1, s1_p2, s1_lt0, s1_lt1, s1_dup} = s1_data;
      s2_r2       = s1_p2 - PORT_SIZE'(s1_lt0) - PORT_SIZE'(s1_lt1);
      s2_index_in = s1_term + (PERM_SIZE'(s1_r1) << 1) + PERM_SIZE'(s2_r2);
      if (s1_dup)
         s2_index_in = '0;
      s2_data_in  = {s1_dup, s2_index_in};
   end

   safe_perm_pipe_stage #(.WIDTH(S2_W)) u_stage2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (s1_valid),
      .in_ready  (s2_in_ready),
      .in_data   (s2_data_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  ({out_err, out_index})
   );

`ifdef SAFE_PERM_RANK_ERR_CNT_EN
   logic [15:0] err_count_d, err_count_q;

   always_comb begin
      err_count_d = err_count_q;
      if (out_valid && out_ready && out_err && (err_count_q != 16'hFFFF))
         err_count_d = err_count_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_count_q <= 16'd0;
      else
         err_count_q <= err_count_d;
   end

   assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_safe_permutation_ranker.sv
// Self-checking bench for safe_permutation_ranker; the reference model is the
// inverse of an enumerated generator table.
module tb_safe_permutation_ranker;

   logic       clk       = 1'b0;
   logic       clk_en    = 1'b1;
   logic       rst_n     = 1'b0;
   logic       in_valid  = 1'b0;
   logic       out_ready = 1'b0;
   logic [5:0] in_perm   = 6'd0;
   logic       in_ready;
   logic       out_valid;
   logic [4:0] out_index;
   logic       out_err;
`ifdef SAFE_PERM_RANK_ERR_CNT_EN
   logic [15:0] err_count;
`endif

   safe_permutation_ranker #(.PERM_SIZE(5), .PORT_SIZE(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_perm   (in_perm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_index (out_index),
      .out_err   (out_err)
`ifdef SAFE_PERM_RANK_ERR_CNT_EN
      ,
      .err_count (err_count)
`endif
   );

   initial forever begin
      #5;
      if (clk_en) clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   logic [5:0] gen_tab [24];

   function automatic logic [5:0] mk(input int a, input int b, input int c);
      return {2'(c), 2'(b), 2'(a)};
   endfunction

   task automatic build_gen();
      for (int i = 0; i < 24; i++) begin
         int rem[$];
         int p0, p1, p2;
         p0 = 3 - i / 6;
         rem = {};
         for (int v = 0; v < 4; v++)
            if (v != p0) rem.push_back(v);
         p1 = rem[(i % 6) / 2];
         rem.delete((i % 6) / 2);
         p2 = rem[i % 2];
         gen_tab[i] = mk(p0, p1, p2);
      end
   endtask

   function automatic void model(input logic [5:0] perm, output logic [4:0] idx, output logic err);
      idx = 5'd0;
      err = 1'b1;
      for (int i = 0; i < 24; i++)
         if (gen_tab[i] == perm) begin
            idx = 5'(i);
            err = 1'b0;
         end
   endfunction

   typedef struct {
      logic [4:0] idx;
      logic       err;
   } exp_t;

   exp_t       exp_q[$];
   bit         mon_en    = 1'b0;
   int         n_out     = 0;
   int         model_err = 0;
   logic       prev_hold = 1'b0;
   logic [4:0] prev_idx  = 5'd0;
   logic       prev_err  = 1'b0;

   // Scoreboard: samples at negedge the transfers that the next posedge performs.
   always @(negedge clk) begin
      if (mon_en) begin
         if (prev_hold) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_index", 32'(out_index), 32'(prev_idx));
            chk("hold_err", 32'(out_err), 32'(prev_err));
         end
         if (in_valid && in_ready) begin
            exp_t e;
            model(in_perm, e.idx, e.err);
            exp_q.push_back(e);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("spurious_out", 32'(out_valid), 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("sb_index", 32'(out_index), 32'(e.idx));
               chk("sb_err", 32'(out_err), 32'(e.err));
               if (e.err) model_err++;
            end
            n_out++;
         end
         prev_hold = out_valid && !out_ready;
         prev_idx  = out_index;
         prev_err  = out_err;
      end else begin
         prev_hold = 1'b0;
      end
   end

   typedef struct {
      logic [5:0] perm;
      logic [4:0] idx;
      logic       err;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input logic [5:0] perm, input int idx, input logic err);
      vec_t v;
      v.perm = perm;
      v.idx  = 5'(idx);
      v.err  = err;
      vecs.push_back(v);
   endtask

   initial begin
      int acc;
      int sent;
      int cycles;
      int err_base;
      logic [5:0] cur;

      build_gen();

      // Reset state, including while still in reset
      #12;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      #10 rst_n = 1'b1;
      @(negedge clk);
      chk("rel_out_valid", 32'(out_valid), 32'd0);
      chk("rel_out_index", 32'(out_index), 32'd0);
      chk("rel_out_err", 32'(out_err), 32'd0);
      chk("rel_in_ready", 32'(in_ready), 32'd1);
`ifdef SAFE_PERM_RANK_ERR_CNT_EN
      chk("rel_err_count", 32'(err_count), 32'd0);
`endif

      // Vector table: anchor points, full enumeration, duplicate entries
      add_vec(mk(3, 0, 1), 0, 1'b0);
      add_vec(mk(3, 0, 2), 1, 1'b0);
      add_vec(mk(2, 0, 3), 7, 1'b0);
      add_vec(mk(2, 3, 0), 10, 1'b0);
      add_vec(mk(0, 1, 2), 18, 1'b0);
      add_vec(mk(0, 3, 2), 23, 1'b0);
      for (int i = 0; i < 24; i++) add_vec(gen_tab[i], i, 1'b0);
      add_vec(mk(1, 1, 2), 0, 1'b1);
      add_vec(mk(0, 3, 0), 0, 1'b1);
      add_vec(mk(2, 2, 2), 0, 1'b1);

      out_ready = 1'b1;
      for (int c = 0; c < vecs.size() + 2; c++) begin
         @(posedge clk); #1;
         if (c < vecs.size()) begin
            in_valid = 1'b1;
            in_perm  = vecs[c].perm;
         end else begin
            in_valid = 1'b0;
            in_perm  = 6'($urandom);
         end
         @(negedge clk);
         chk("tbl_in_ready", 32'(in_ready), 32'd1);
         if (c >= 2) begin
            chk("tbl_valid", 32'(out_valid), 32'd1);
            chk("tbl_index", 32'(out_index), 32'(vecs[c-2].idx));
            chk("tbl_err", 32'(out_err), 32'(vecs[c-2].err));
         end else begin
            chk("tbl_latency", 32'(out_valid), 32'd0);
         end
      end
      @(posedge clk); #1;
      @(negedge clk);
      chk("tbl_drained", 32'(out_valid), 32'd0);
`ifdef SAFE_PERM_RANK_ERR_CNT_EN
      chk("tbl_err_count", 32'(err_count), 32'd3);
`endif
      err_base = 3;

      // Output stall with continuous input: two slots fill, then backpressure
      mon_en    = 1'b1;
      model_err = 0;
      n_out     = 0;
      out_ready = 1'b0;
      acc       = 0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         in_perm  = gen_tab[(c * 5 + 3) % 24];
         @(negedge clk);
         if (in_valid && in_ready) acc++;
      end
      chk("stall_accepted", 32'(acc), 32'd2);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("stall_drain_count", 32'(n_out), 32'd2);
      chk("stall_queue_empty", 32'(exp_q.size()), 32'd0);

      // Random valid/ready traffic against the model
      n_out  = 0;
      sent   = 0;
      cycles = 0;
      cur    = 6'($urandom);
      while ((sent < 10000 || exp_q.size() > 0) && cycles < 80000) begin
         @(posedge clk); #1;
         in_valid  = (sent < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
         in_perm   = in_valid ? cur : 6'($urandom);
         out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (in_valid && in_ready) begin
            sent++;
            cur = 6'($urandom);
         end
         cycles++;
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("rand_no_timeout", 32'(cycles < 80000), 32'd1);
      chk("rand_out_count", 32'(n_out), 32'd10000);
      chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);
`ifdef SAFE_PERM_RANK_ERR_CNT_EN
      chk("rand_err_count", 32'(err_count),
          (err_base + model_err > 65535) ? 32'd65535 : 32'(err_base + model_err));
`endif

      // Reset with two items in flight and the clock stopped
      mon_en    = 1'b0;
      out_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         in_perm  = gen_tab[c + 11];
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("flight_out_valid", 32'(out_valid), 32'd1);
      chk("flight_in_ready", 32'(in_ready), 32'd0);
      clk_en = 1'b0;
      #7 rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", 32'(out_valid), 32'd0);
      chk("async_rst_out_index", 32'(out_index), 32'd0);
      chk("async_rst_in_ready", 32'(in_ready), 32'd1);
`ifdef SAFE_PERM_RANK_ERR_CNT_EN
      chk("async_rst_err_count", 32'(err_count), 32'd0);
`endif
      #10 rst_n = 1'b1;
      #2 clk_en = 1'b1;
      exp_q.delete();
      out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("post_rst_no_stale", 32'(out_valid), 32'd0);
      end

`ifdef SAFE_PERM_RANK_ERR_CNT_EN
      // Saturation: 65537 duplicate-entry inputs
      for (int k = 0; k < 65537; k++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         in_perm  = mk(0, 0, 0);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("sat_err_count", 32'(err_count), 32'hFFFF);
      chk("sat_out_err", 32'(out_err), 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
